// File: rtl/divisor_seq.sv
// -----------------------------------------------------------------------------
// divisor_seq
//
// Iterative 32-bit integer divider (DIV / DIVU) for the multicycle datapath.
// Restoring shift-subtract, one quotient bit per clock. The control unit pulses
// `start` in IDLE, stalls while `busy` is high and writes HI/LO when `done`
// pulses.
//
// Result convention: the quotient truncates toward zero and the remainder takes
// the sign of the dividend. 0x80000000 / 0xFFFFFFFF (signed) wraps to
// lo = 0x80000000, hi = 0 without any exception.
//
// Ports:
//   clock      in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset
//   start      in   1   operation request, sampled only in IDLE
//   is_signed  in   1   1 = DIV (two's complement), 0 = DIVU; captured with start
//   dividendo  in  32   dividend, captured with start
//   divisor    in  32   divisor, captured with start
//   hi         out 32   remainder (registered, held until the next result)
//   lo         out 32   quotient  (registered, held until the next result)
//   busy       out  1   operation in progress (PREP, RUN, FIX)
//   div_zero   out  1   divide-by-zero flag (only with DIVISOR_SEQ_DIVZERO_EN)
//   done       out  1   one-cycle pulse when hi/lo carry a new result
//
// Build option:
//   DIVISOR_SEQ_DIVZERO_EN  When defined, a zero divisor is detected in PREP:
//                           the operation jumps straight to DONE, div_zero is
//                           raised and hi/lo keep their previous contents.
//                           When undefined, a zero divisor runs the full
//                           sequence and loads whatever the datapath produces
//                           (for DIVU: lo = 0xFFFFFFFF, hi = dividend).
//
// Timing (cycle 0 = cycle in which start is sampled high):
//   PREP = 1, RUN = 2..33, FIX = 34, DONE = 35. busy is high in 1..34.
//   With the zero-divisor option, a zero divisor gives DONE in cycle 2.
// -----------------------------------------------------------------------------
module divisor_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividendo,
    input  logic [31:0] divisor,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
`ifdef DIVISOR_SEQ_DIVZERO_EN
    output logic        div_zero,
`endif
    output logic        done
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREP = 3'd1;
    localparam logic [2:0] RUN  = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [4:0] LAST_ITER = 5'd31;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [2:0]  state_q, state_d;
    // Holds the dividend magnitude; quotient bits shift in from the right as
    // dividend bits shift out of the left into the partial remainder.
    logic [31:0] quo_q,   quo_d;
    logic [31:0] dsr_q,   dsr_d;    // divisor (magnitude after PREP)
    logic [32:0] rem_q,   rem_d;    // partial remainder
    logic [4:0]  cnt_q,   cnt_d;    // iteration counter
    logic        sgn_q,   sgn_d;    // captured is_signed
    logic        qneg_q,  qneg_d;   // quotient must be negated in FIX
    logic        rneg_q,  rneg_d;   // remainder must be negated in FIX
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;
`ifdef DIVISOR_SEQ_DIVZERO_EN
    logic        dz_q,    dz_d;
`endif

    // -------------------------------------------------------------------------
    // Trial subtraction
    // -------------------------------------------------------------------------
    // The shifted remainder is carried at 34 bits so the subtraction borrow
    // lands in bit 33 without ever aliasing a legitimate remainder bit. The
    // partial remainder never exceeds 32 significant bits (it is either below
    // the divisor, or, for a zero divisor, the dividend bits shifted in so far),
    // so bit 32 of rem_q is always zero in practice.
    logic [33:0] shifted;
    logic [33:0] diff;
    logic        diff_neg;

    always_comb begin
        shifted  = {rem_q, quo_q[31]};
        diff     = shifted - {2'b00, dsr_q};
        diff_neg = diff[33];
    end

    // -------------------------------------------------------------------------
    // Operand magnitudes for PREP
    // -------------------------------------------------------------------------
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    always_comb begin
        a_neg = sgn_q & quo_q[31];
        b_neg = sgn_q & dsr_q[31];
        // -0x80000000 wraps to 0x80000000, which is the correct unsigned
        // magnitude, so no special case is needed for the most negative value.
        a_mag = a_neg ? (32'd0 - quo_q) : quo_q;
        b_mag = b_neg ? (32'd0 - dsr_q) : dsr_q;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef DIVISOR_SEQ_DIVZERO_EN
        dz_d    = dz_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    quo_d   = dividendo;
                    dsr_d   = divisor;
                    sgn_d   = is_signed;
`ifdef DIVISOR_SEQ_DIVZERO_EN
                    dz_d    = 1'b0;
`endif
                    state_d = PREP;
                end
            end

            PREP: begin
                quo_d   = a_mag;
                dsr_d   = b_mag;
                qneg_d  = a_neg ^ b_neg;
                rneg_d  = a_neg;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = RUN;
`ifdef DIVISOR_SEQ_DIVZERO_EN
                // Zero divisor: skip the datapath, leave hi/lo untouched.
                if (dsr_q == 32'd0) begin
                    dz_d    = 1'b1;
                    state_d = DONE;
                end
`endif
            end

            RUN: begin
                if (!diff_neg) begin
                    rem_d = diff[32:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted[32:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                lo_d    = qneg_q ? (32'd0 - quo_q) : quo_q;
                hi_d    = rneg_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
                state_d = DONE;
            end

            DONE: begin
                // start is deliberately ignored here; the requester re-asserts
                // it once the divider is back in IDLE.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            quo_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef DIVISOR_SEQ_DIVZERO_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef DIVISOR_SEQ_DIVZERO_EN
            dz_q    <= dz_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (busy/done are Moore decodes of the state register)
    // -------------------------------------------------------------------------
    always_comb begin
        hi   = hi_q;
        lo   = lo_q;
        busy = (state_q == PREP) || (state_q == RUN) || (state_q == FIX);
        done = (state_q == DONE);
    end

`ifdef DIVISOR_SEQ_DIVZERO_EN
    assign div_zero = dz_q;
`endif

endmodule

// File: doc/divisor_seq.md
# divisor_seq

Iterative 32-bit integer divider for the multicycle datapath, producing quotient and remainder for DIV/DIVU. It sits directly upstream of the 32-bit 2:1 result multiplexers, and its `hi` and `lo` outputs are wired to their data inputs. The control unit starts it with a one-cycle pulse, stalls on `busy`, and writes HI/LO on `done`. It uses a restoring shift-subtract algorithm with one quotient bit per cycle.

## Interface
Parameters:
- None. Width is fixed at 32 bits.

Ports:
- `clock`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-high; forces IDLE and the output reset values.
- `start`  in  1  — operation request; sampled only in IDLE.
- `is_signed`  in  1  — 1 = DIV (two's complement), 0 = DIVU; captured with `start`.
- `dividendo`  in  32  — dividend; captured with `start`.
- `divisor`  in  32  — divisor; captured with `start`.
- `hi`  out  32  — remainder, registered.
- `lo`  out  32  — quotient, registered.
- `busy`  out  1  — operation in progress.
- `done`  out  1  — one-cycle pulse when `hi`/`lo` carry a new result.
- `div_zero`  out  1  — divide-by-zero flag. Present only with `DIVISOR_SEQ_DIVZERO_EN`.

## Operation
- FSM states: IDLE, PREP, RUN, FIX, DONE.
- **IDLE:**
  - `start`=1 captures `dividendo`, `divisor` and `is_signed`, clears `div_zero`, and moves to PREP.
  - Otherwise the FSM stays in IDLE.
- **PREP:**
  - If signed, take the absolute values of both operands and record the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a)).
  - Clear the 33-bit partial remainder and the 5-bit iteration counter, then move to RUN.
- **RUN (32 cycles):**
  - Shift {remainder, dividend} left by 1, then trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - After counter = 31, move to FIX.
- **FIX:**
  - Negate the quotient if its sign flag is set; negate the remainder if the dividend was negative.
  - Load `hi`/`lo`, then move to DONE.
- **DONE:**
  - `done`=1 for this cycle only; always return to IDLE.
- **Arithmetic rules:**
  - All magnitudes are treated as unsigned 32-bit values.
  - The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives `lo`=0x80000000, `hi`=0. No exception is raised.
- **Input and result holding:**
  - Operand changes after capture are ignored.
  - `hi`/`lo` hold the last result until the next FIX or a reset.
- **Start handling:**
  - `start` outside IDLE is ignored. This includes DONE; the requester must re-assert `start` in IDLE.
- **Reset values:**
  - `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, state IDLE.
  - Reset mid-operation aborts the operation with no result written.

## Timing
- **Cycle numbering:** cycle 0 is the cycle in which `start` is sampled high.
- **Sequence:** PREP is cycle 1, RUN is cycles 2–33, FIX is cycle 34, DONE is cycle 35.
- **`busy`:** high in cycles 1–34 and low in DONE. This is a Moore output decoded from the state.
- **`done`:** high in cycle 35 only. `hi`/`lo` are valid from cycle 35 onward.
- **Throughput:** the earliest next accepted `start` is cycle 36, in IDLE.
- **Divide-by-zero path:** a zero divisor with the macro defined completes in 3 cycles, with `done` high in cycle 2.

## Configuration
- **Macro:** `DIVISOR_SEQ_DIVZERO_EN`.
- **Defined:**
  - In PREP, a divisor of 0 skips RUN/FIX and goes directly to DONE.
  - `div_zero` is set to 1; `hi`/`lo` keep their previous values.
  - `div_zero` stays high until the next accepted `start`.
- **Undefined:**
  - The `div_zero` port and its detection logic are absent.
  - A zero divisor runs the full 35-cycle sequence and loads whatever the datapath produces.
  - For DIVU that result is `lo`=0xFFFFFFFF and `hi`=dividend.

## Test plan
- **DIVU, 100 / 7:**
  - `lo`=14, `hi`=2.
  - `busy` high cycles 1–34, `done` a single pulse in cycle 35.
- **DIV, −100 / 7 (0xFFFFFF9C / 7):**
  - `lo`=0xFFFFFFF2 (−14), `hi`=0xFFFFFFFE (−2).
- **DIV, 0x80000000 / 0xFFFFFFFF:**
  - `lo`=0x80000000, `hi`=0.
- **Zero divisor, DIVU 5 / 0:**
  - With the macro: `done` in cycle 2, `div_zero`=1, `hi`/`lo` unchanged.
  - Without the macro: `done` in cycle 35, `lo`=0xFFFFFFFF, `hi`=5.
- **Start and operand handling during an operation:**
  - Assert `start` with new operands in cycles 10 and 35, and change `dividendo` in cycle 5.
  - Both starts are ignored and the result is unaffected.
  - A `start` in cycle 36 is accepted.
- **Async reset in cycle 20:**
  - All outputs return to 0 immediately, with no `done`.
  - A new `start` after reset deassertion completes normally.
